// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole game core:
// FSM states, spawn interval table, LFSR seed and feedback taps.
package whack_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_PAUSED,
      S_OVER
   } state_e;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Right-shift form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   // Ticks between spawn points for each difficulty level
   function automatic logic [7:0] spawn_ivl(input logic [1:0] diff);
      logic [7:0] ivl;
      case (diff)
         2'd0:    ivl = 8'd100;
         2'd1:    ivl = 8'd70;
         2'd2:    ivl = 8'd50;
         default: ivl = 8'd30;
      endcase
      return ivl;
   endfunction

   // One LFSR step; an all-zero state is forced back to the seed
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      logic [15:0] n;
      n = {^(s & LFSR_TAPS), s[15:1]};
      if (n == 16'h0000) n = LFSR_SEED;
      return n;
   endfunction

endpackage

// File: rtl/mole_slot.sv
// One hole: lit flag plus a lifetime down-counter in game ticks.
// clear beats hit beats spawn beats expiry.
module mole_slot (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear_i,
   input  logic       spawn_i,
   input  logic       hit_i,
   input  logic       tick_i,
   input  logic [7:0] life_i,
   output logic       lit_o
);

   logic       lit_q, lit_d;
   logic [7:0] cnt_q, cnt_d;

   // next lit/lifetime state for this hole
   always_comb begin
      lit_d = lit_q;
      cnt_d = cnt_q;
      if (clear_i || hit_i) begin
         lit_d = 1'b0;
         cnt_d = '0;
      end else if (spawn_i) begin
         lit_d = 1'b1;
         cnt_d = life_i;
      end else if (lit_q && tick_i) begin
         if (cnt_q <= 8'd1) begin
            lit_d = 1'b0;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q - 8'd1;
         end
      end
   end

   // hole state register
   always_ff @(posedge clk) begin
      if (rst) begin
         lit_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         lit_q <= lit_d;
         cnt_q <= cnt_d;
      end
   end

   assign lit_o = lit_q;

endmodule

// File: rtl/whack_game_core.sv
// Whack-a-mole game core: FSM, tick/second timers, mole spawning, scoring.
// Define WHACK_HISCORE_EN to keep a best-score register across games.
module whack_game_core
   import whack_pkg::*;
#(
   parameter int N_HOLES     = 8,
   parameter int SCORE_W     = 12,
   parameter int TICK_CYCLES = 1_000_000,
   parameter int SEC_TICKS   = 100,
   parameter int GAME_SECS   = 30
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               pause,
   input  logic [1:0]         difficulty,
   input  logic [N_HOLES-1:0] tap,
   output logic [N_HOLES-1:0] holes,
   output logic [SCORE_W-1:0] score,
   output logic [5:0]         time_left,
   output logic               running,
   output logic               game_over,
   output logic [SCORE_W-1:0] hi_score
);

   localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int SEC_W  = (SEC_TICKS > 1) ? $clog2(SEC_TICKS) : 1;
   localparam int SUM_W  = SCORE_W + 8;

   state_e              state_q;
   logic [1:0]          diff_q;
   logic [TICK_W-1:0]   tick_q;
   logic [SEC_W-1:0]    sec_q;
   logic [7:0]          spawn_q;
   logic [5:0]          time_q;
   logic [SCORE_W-1:0]  score_q, score_d;
   logic                running_q, over_q;
   logic [15:0]         lfsr_q;

   logic                run, tick, sec, spawn_pt, game_end, start_ok;
   logic [7:0]          ivl, life, cand;
   logic [N_HOLES-1:0]  lit, hit, miss, cand_oh;
   logic [4:0]          lit_cnt, n_hit, n_miss;
   logic                spawn_ok;
   logic [SUM_W-1:0]    pts, up, top;

   assign run      = (state_q == S_RUN);
   assign start_ok = start && (state_q == S_IDLE || state_q == S_OVER);
   assign tick     = run && (tick_q == TICK_W'(TICK_CYCLES - 1));
   assign sec      = tick && (sec_q == SEC_W'(SEC_TICKS - 1));
   assign game_end = sec && (time_q == 6'd1);
   assign ivl      = spawn_ivl(diff_q);
   assign life     = {ivl[6:0], 1'b0};
   assign spawn_pt = tick && (spawn_q == ivl - 8'd1);
   assign cand     = lfsr_q[7:0] % 8'(N_HOLES);
   assign cand_oh  = N_HOLES'(1) << cand;
   assign hit      = run ? (tap & lit) : '0;
   assign miss     = run ? (tap & ~lit) : '0;
   assign spawn_ok = spawn_pt && ~|(cand_oh & lit)
                     && (lit_cnt <= {3'b000, diff_q});

   // lit-hole, hit and miss population counts
   always_comb begin
      lit_cnt = '0;
      n_hit   = '0;
      n_miss  = '0;
      for (int i = 0; i < N_HOLES; i++) begin
         lit_cnt = lit_cnt + 5'(lit[i]);
         n_hit   = n_hit + 5'(hit[i]);
         n_miss  = n_miss + 5'(miss[i]);
      end
   end

   // net score delta applied once, saturating at both ends
   always_comb begin
      pts = SUM_W'(n_hit) * (SUM_W'(diff_q) + SUM_W'(1));
      up  = SUM_W'(score_q) + pts;
      top = SUM_W'({SCORE_W{1'b1}});
      if (up < SUM_W'(n_miss)) begin
         score_d = '0;
      end else if (up - SUM_W'(n_miss) > top) begin
         score_d = '1;
      end else begin
         score_d = SCORE_W'(up - SUM_W'(n_miss));
      end
   end

   for (genvar g = 0; g < N_HOLES; g++) begin : g_slot
      mole_slot u_slot (
         .clk     (clk),
         .rst     (rst),
         .clear_i (start_ok || game_end),
         .spawn_i (spawn_ok && cand_oh[g]),
         .hit_i   (hit[g]),
         .tick_i  (tick),
         .life_i  (life),
         .lit_o   (lit[g])
      );
   end

   // free-running random source, advances in every state
   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= LFSR_SEED;
      else     lfsr_q <= lfsr_next(lfsr_q);
   end

   // game FSM with timers, score and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         diff_q    <= '0;
         tick_q    <= '0;
         sec_q     <= '0;
         spawn_q   <= '0;
         time_q    <= 6'(GAME_SECS);
         score_q   <= '0;
         running_q <= 1'b0;
         over_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_OVER: begin
               if (start) begin
                  state_q   <= S_RUN;
                  diff_q    <= difficulty;
                  tick_q    <= '0;
                  sec_q     <= '0;
                  spawn_q   <= '0;
                  time_q    <= 6'(GAME_SECS);
                  score_q   <= '0;
                  running_q <= 1'b1;
                  over_q    <= 1'b0;
               end
            end
            S_RUN: begin
               tick_q <= tick ? '0 : tick_q + TICK_W'(1);
               if (tick) begin
                  sec_q   <= sec ? '0 : sec_q + SEC_W'(1);
                  spawn_q <= spawn_pt ? '0 : spawn_q + 8'd1;
               end
               if (sec) time_q <= time_q - 6'd1;
               if (game_end) begin
                  state_q   <= S_OVER;
                  running_q <= 1'b0;
                  over_q    <= 1'b1;
               end else begin
                  score_q <= score_d;
                  if (pause) state_q <= S_PAUSED;
               end
            end
            S_PAUSED: begin
               if (!pause) state_q <= S_RUN;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef WHACK_HISCORE_EN
   logic [SCORE_W-1:0] hi_q;

   // best final score, updated only when a game runs out of time
   always_ff @(posedge clk) begin
      if (rst) hi_q <= '0;
      else if (game_end && score_q > hi_q) hi_q <= score_q;
   end

   assign hi_score = hi_q;
`else
   assign hi_score = '0;
`endif

   assign holes     = lit;
   assign score     = score_q;
   assign time_left = time_q;
   assign running   = running_q;
   assign game_over = over_q;

endmodule
